// File: rtl/serial_add_seq.sv
// Bit-serial adder: drives one full-adder cell for WIDTH cycles, LSB first, to form
// a+b+carry_in. Start/busy/done handshake; the result holds until the next operation completes.
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             carry_in,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             carry
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);
  localparam logic [CW-1:0] CNT_ONE  = CW'(1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // One-bit full-adder cell: returns {carry, sum}.
  function automatic logic [1:0] full_add(input logic x, input logic y, input logic ci);
    full_add = {(x & y) | (x & ci) | (y & ci), x ^ y ^ ci};
  endfunction

  state_t           state_r, state_next_s;
  logic [WIDTH-1:0] a_sh_r, b_sh_r, psum_r, sum_r;
  logic [CW-1:0]    cnt_r;
  logic             cy_r, carry_r, busy_r, done_r;
  logic [1:0]       fa_s;
  logic [WIDTH-1:0] psum_shift_s;
  logic             last_bit_s;

  // Full-adder datapath and next-state decode.
  always_comb begin
    state_next_s  = state_r;
    fa_s          = full_add(a_sh_r[0], b_sh_r[0], cy_r);
    // Shift right, then drop the new sum bit into the MSB; also valid for WIDTH=1.
    psum_shift_s  = psum_r >> 1;
    psum_shift_s[WIDTH-1] = fa_s[0];
    last_bit_s    = (cnt_r == CNT_LAST);
    case (state_r)
      IDLE: begin
        if (start) state_next_s = RUN;
        else       state_next_s = IDLE;
      end
      RUN: begin
        if (last_bit_s) state_next_s = DONE;
        else            state_next_s = RUN;
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State, operand shifters, carry, counter and result registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
      a_sh_r  <= '0;
      b_sh_r  <= '0;
      psum_r  <= '0;
      cy_r    <= 1'b0;
      cnt_r   <= '0;
      sum_r   <= '0;
      carry_r <= 1'b0;
    end else begin
      state_r <= state_next_s;
      busy_r  <= (state_next_s == RUN);
      done_r  <= (state_next_s == DONE);
      case (state_r)
        IDLE: begin
          if (start) begin
            a_sh_r <= a;
            b_sh_r <= b;
            cy_r   <= carry_in;
            cnt_r  <= '0;
            psum_r <= '0;
          end
        end
        RUN: begin
          a_sh_r <= a_sh_r >> 1;
          b_sh_r <= b_sh_r >> 1;
          psum_r <= psum_shift_s;
          cy_r   <= fa_s[1];
          if (last_bit_s) begin
            sum_r   <= psum_shift_s;
            carry_r <= fa_s[1];
          end else begin
            cnt_r <= cnt_r + CNT_ONE;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy  = busy_r;
  assign done  = done_r;
  assign sum   = sum_r;
  assign carry = carry_r;

endmodule

// File: tb/tb_serial_add_seq.sv
// Directed self-checking bench for serial_add_seq at WIDTH=8 and WIDTH=1.
module tb_serial_add_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, start8, cin8, busy8, done8, carry8;
  logic [7:0] a8, b8, sum8;
  logic       start1, cin1, busy1, done1, carry1;
  logic [0:0] a1, b1, sum1;

  int checks = 0;
  int errors = 0;

  serial_add_seq #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .carry_in(cin8),
    .busy(busy8), .done(done8), .sum(sum8), .carry(carry8)
  );

  serial_add_seq #(.WIDTH(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .carry_in(cin1),
    .busy(busy1), .done(done1), .sum(sum1), .carry(carry1)
  );

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Issue one WIDTH=8 operation from IDLE and check latency, busy length and result.
  task automatic run8(input string tag, input logic [7:0] a, input logic [7:0] b, input logic c,
                      input logic [7:0] es, input logic ec);
    int n;
    int nb;
    a8 = a; b8 = b; cin8 = c; start8 = 1'b1;
    step();
    start8 = 1'b0;
    n = 0; nb = 0;
    while (!done8 && n < 20) begin
      if (busy8) nb++;
      step();
      n++;
    end
    check_eq({tag, "_lat"},   32'(n), 32'(8));
    check_eq({tag, "_busy"},  32'(nb), 32'(8));
    check_eq({tag, "_sum"},   32'(sum8), 32'(es));
    check_eq({tag, "_carry"}, 32'(carry8), 32'(ec));
    check_eq({tag, "_dbusy"}, 32'(busy8), 32'(1'b0));
    step();
    check_eq({tag, "_dlen"},  32'(done8), 32'(1'b0));
  endtask

  initial begin
    int n, w, last, pulses, extra;
    logic prevd;
    logic [1:0] exp1;
    reset = 1'b1; start8 = 1'b0; a8 = 8'h00; b8 = 8'h00; cin8 = 1'b0;
    start1 = 1'b0; a1 = 1'b0; b1 = 1'b0; cin1 = 1'b0;
    step(); step();
    check_eq("rst_busy",  32'(busy8),  32'(1'b0));
    check_eq("rst_done",  32'(done8),  32'(1'b0));
    check_eq("rst_sum",   32'(sum8),   32'(8'h00));
    check_eq("rst_carry", 32'(carry8), 32'(1'b0));
    reset = 1'b0;
    step();

    // T1, T2
    run8("t1", 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1);
    run8("t2", 8'h5A, 8'h33, 1'b1, 8'h8E, 1'b0);
    extra = 0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (sum8 !== 8'h8E || done8) extra++;
    end
    check_eq("t2_hold", 32'(extra), 32'(0));

    // T3: start held high
    a8 = 8'h5A; b8 = 8'h33; cin8 = 1'b1; start8 = 1'b1;
    w = 0; last = -1; pulses = 0; prevd = 1'b0;
    for (int cyc = 0; cyc < 45; cyc++) begin
      step();
      if (done8 && !prevd) begin
        if (last >= 0) check_eq("t3_period", 32'(cyc - last), 32'(10));
        last = cyc;
        pulses++;
        check_eq("t3_sum", 32'(sum8), 32'(8'h8E));
      end
      if (done8) w++;
      else if (w > 0) begin
        check_eq("t3_width", 32'(w), 32'(1));
        w = 0;
      end
      prevd = done8;
    end
    start8 = 1'b0;
    check_eq("t3_count", 32'(pulses), 32'(4));
    for (int i = 0; i < 12; i++) step();
    check_eq("t3_idle", 32'(busy8), 32'(1'b0));

    // T4: start pulses during RUN/DONE, operands change mid-RUN
    a8 = 8'h5A; b8 = 8'h33; cin8 = 1'b1; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step(); step(); step();
    start8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; cin8 = 1'b0;
    step();
    start8 = 1'b0;
    step();
    n = 0;
    while (!done8 && n < 20) begin
      step();
      n++;
    end
    check_eq("t4_lat",   32'(n), 32'(3));
    check_eq("t4_sum",   32'(sum8), 32'(8'h8E));
    check_eq("t4_carry", 32'(carry8), 32'(1'b0));
    start8 = 1'b1;
    step();
    start8 = 1'b0;
    extra = 0;
    for (int i = 0; i < 15; i++) begin
      step();
      if (done8 || busy8) extra++;
    end
    check_eq("t4_extra", 32'(extra), 32'(0));

    // T5: reset at the 4th RUN edge
    a8 = 8'h5A; b8 = 8'h33; cin8 = 1'b1; start8 = 1'b1;
    step();
    start8 = 1'b0;
    step(); step(); step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check_eq("t5_busy",  32'(busy8),  32'(1'b0));
    check_eq("t5_done",  32'(done8),  32'(1'b0));
    check_eq("t5_sum",   32'(sum8),   32'(8'h00));
    check_eq("t5_carry", 32'(carry8), 32'(1'b0));
    extra = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done8 || busy8) extra++;
    end
    check_eq("t5_nodone", 32'(extra), 32'(0));
    run8("t5b", 8'h80, 8'h80, 1'b0, 8'h00, 1'b1);

    // T6: WIDTH=1 full-adder truth table
    for (int i = 0; i < 8; i++) begin
      a1 = i[2]; b1 = i[1]; cin1 = i[0];
      exp1 = 2'(i[2]) + 2'(i[1]) + 2'(i[0]);
      start1 = 1'b1;
      step();
      start1 = 1'b0;
      check_eq("t6_busy",  32'(busy1),  32'(1'b1));
      step();
      check_eq("t6_done",  32'(done1),  32'(1'b1));
      check_eq("t6_sum",   32'(sum1),   32'(exp1[0]));
      check_eq("t6_carry", 32'(carry1), 32'(exp1[1]));
      step();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
